// File: rtl/shift_mult_pkg.sv
// Shared types and helpers for the shift-add multiplier controller and the
// top level that will later connect it to the register and adder datapath.
package shift_mult_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } ctrl_state_t;

    // Width needed to hold the values 0..width (the iteration count)
    function automatic int unsigned ctr_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_mult_controller.sv
// Sequencing FSM for a shift-add multiplier: loads the datapath, then for each
// multiplier bit inspects q0, optionally adds, and shifts. It holds done until
// the result is acknowledged or a new multiply is requested.
module shift_mult_controller
    import shift_mult_pkg::*;
#(
    parameter  int n  = 4,
    localparam int CW = ctr_width(n)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          ack,
    input  logic          abort,
    input  logic          q0,
    output logic          load,
    output logic          add,
    output logic          shift,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] iter
);

    ctrl_state_t state;
    ctrl_state_t state_next;
    logic [CW-1:0] iter_next;
    logic in_op;

    // Operation in progress: the states where abort applies and busy is high
    assign in_op = (state == LOAD) || (state == CHECK) ||
                   (state == ADD)  || (state == SHIFT);

    // State and iteration counter registers, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            iter  <= '0;
        end else begin
            state <= state_next;
            iter  <= iter_next;
        end
    end

    // Next-state and counter update; abort overrides every other transition
    always_comb begin
        state_next = IDLE;
        iter_next  = iter;
        if (in_op && abort) begin
            state_next = IDLE;
            iter_next  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = start ? LOAD : IDLE;
                end
                LOAD: begin
                    iter_next  = CW'(n);
                    state_next = CHECK;
                end
                CHECK: begin
                    state_next = q0 ? ADD : SHIFT;
                end
                ADD: begin
                    state_next = SHIFT;
                end
                SHIFT: begin
                    // SHIFT is only reached with iter >= 1, so no underflow
                    iter_next  = iter - CW'(1);
                    state_next = (iter == CW'(1)) ? DONE : CHECK;
                end
                DONE: begin
                    // A new start wins over ack for back-to-back operation
                    if (start) begin
                        state_next = LOAD;
                    end else if (ack) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DONE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded from state only; strobes are mutually exclusive
    always_comb begin
        load  = 1'b0;
        add   = 1'b0;
        shift = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            LOAD: begin
                load = 1'b1;
                busy = 1'b1;
            end
            CHECK: begin
                busy = 1'b1;
            end
            ADD: begin
                add  = 1'b1;
                busy = 1'b1;
            end
            SHIFT: begin
                shift = 1'b1;
                busy  = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_mult_controller.sv
// Directed bench for shift_mult_controller with a small behavioural
// shift-add datapath driven by the controller strobes.
module tb_shift_mult_controller;

    localparam int N  = 4;
    localparam int CW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          ack   = 1'b0;
    logic          abort = 1'b0;
    logic          q0;
    logic          load;
    logic          add;
    logic          shift;
    logic          busy;
    logic          done;
    logic [CW-1:0] iter;

    // Behavioural datapath: carry C, accumulator A, multiplier Q, multiplicand M
    logic          dp_c   = 1'b0;
    logic [N-1:0]  dp_a   = '0;
    logic [N-1:0]  dp_q   = '0;
    logic [N-1:0]  dp_m   = '0;
    logic [N-1:0]  dp_qin = '0;

    int checks = 0;
    int errors = 0;

    shift_mult_controller #(.n(N)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .ack   (ack),
        .abort (abort),
        .q0    (q0),
        .load  (load),
        .add   (add),
        .shift (shift),
        .busy  (busy),
        .done  (done),
        .iter  (iter)
    );

    always #5 clock = ~clock;

    assign q0 = dp_q[0];

    // Datapath register model reacting to the controller strobes
    always @(posedge clock) begin
        if (load) begin
            dp_c <= 1'b0;
            dp_a <= '0;
            dp_q <= dp_qin;
        end else if (add) begin
            {dp_c, dp_a} <= {1'b0, dp_a} + {1'b0, dp_m};
        end else if (shift) begin
            {dp_c, dp_a, dp_q} <= {dp_c, dp_a, dp_q} >> 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit past the edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] strobes();
        return {29'd0, load, add, shift};
    endfunction

    function automatic logic [31:0] onehot_ok();
        return {31'd0, (int'(load) + int'(add) + int'(shift)) <= 1};
    endfunction

    // Run one multiply a*b from IDLE or DONE; optionally present ack with start
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic with_ack, input int ack_delay,
                          output int busy_cnt, output int add_cnt);
        int guard;
        dp_m   = a;
        dp_qin = b;
        start  = 1'b1;
        ack    = with_ack;
        step();
        start  = 1'b0;
        ack    = 1'b0;
        chk("op_first_load", {31'd0, load}, 32'd1);
        chk("op_first_done", {31'd0, done}, 32'd0);
        busy_cnt = 0;
        add_cnt  = 0;
        guard    = 0;
        while (busy && guard < 100) begin
            chk("op_onehot", onehot_ok(), 32'd1);
            busy_cnt += 1;
            add_cnt  += int'(add);
            step();
            guard++;
        end
        chk("op_done", {31'd0, done}, 32'd1);
        chk("op_product", {24'd0, dp_a, dp_q}, 32'(a) * 32'(b));
        for (int i = 0; i < ack_delay; i++) begin
            step();
            chk("op_done_hold", {31'd0, done}, 32'd1);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("op_ack_idle", {30'd0, busy, done}, 32'd0);
    endtask

    int exp_code [12] = '{4, 0, 2, 1, 0, 2, 1, 0, 1, 0, 2, 1};
    int exp_iter [12] = '{0, 4, 4, 4, 3, 3, 3, 2, 2, 1, 1, 1};

    // Directed stimulus sequence
    initial begin
        int bc;
        int ac;
        int guard;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        // Reset state
        reset = 1'b1;
        #2;
        chk("rst_outputs", {27'd0, load, add, shift, busy, done}, 32'd0);
        chk("rst_iter", 32'(iter), 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("idle_outputs", {27'd0, load, add, shift, busy, done}, 32'd0);

        // Multiplier 1011 with multiplicand 6: full strobe sequence and iter
        dp_m   = 4'd6;
        dp_qin = 4'b1011;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("seq_strobe_%0d", i), strobes(), 32'(exp_code[i]));
            chk($sformatf("seq_busy_%0d", i), {31'd0, busy}, 32'd1);
            chk($sformatf("seq_iter_%0d", i), 32'(iter), 32'(exp_iter[i]));
            step();
        end
        chk("seq_done", {30'd0, busy, done}, 32'd1);
        chk("seq_iter_done", 32'(iter), 32'd0);
        chk("seq_product", {24'd0, dp_a, dp_q}, 32'd66);

        // Done hold with ack low
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_done", {30'd0, busy, done}, 32'd1);
            chk("hold_strobes", strobes(), 32'd0);
            chk("hold_product", {24'd0, dp_a, dp_q}, 32'd66);
        end

        // start and ack together from DONE: back-to-back, multiplier 0
        run_op(4'd5, 4'd0, 1'b1, 0, bc, ac);
        chk("zero_busy", 32'(bc), 32'd9);
        chk("zero_adds", 32'(ac), 32'd0);

        // Multiplier F
        run_op(4'd7, 4'hF, 1'b0, 2, bc, ac);
        chk("f_busy", 32'(bc), 32'd13);
        chk("f_adds", 32'(ac), 32'd4);

        // start pulsed during SHIFT is ignored
        dp_m   = 4'd3;
        dp_qin = 4'd0;
        start  = 1'b1;
        step();
        start  = 1'b0;
        step();
        step();
        chk("mid_in_shift", strobes(), 32'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("mid_no_load", {31'd0, load}, 32'd0);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_iter", 32'(iter), 32'd3);
        guard = 0;
        while (busy && guard < 100) begin
            step();
            guard++;
        end
        chk("mid_done", {31'd0, done}, 32'd1);
        chk("mid_product", {24'd0, dp_a, dp_q}, 32'd0);
        ack = 1'b1;
        step();
        ack = 1'b0;

        // abort in CHECK
        dp_qin = 4'b0110;
        start  = 1'b1;
        step();
        start  = 1'b0;
        step();
        chk("abort_in_check", {30'd0, busy, load}, 32'd2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_outputs", {27'd0, load, add, shift, busy, done}, 32'd0);
        chk("abort_iter", 32'(iter), 32'd0);
        step();
        chk("abort_stays_idle", {30'd0, busy, done}, 32'd0);

        // Random operations: strobe exclusivity, latency and product
        for (int k = 0; k < 1000; k++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            run_op(ra, rb, 1'b0, int'($urandom_range(0, 3)), bc, ac);
            chk("rand_busy", 32'(bc), 32'(1 + 2 * N + $countones(rb)));
        end

        // Asynchronous reset while in ADD
        dp_m   = 4'd9;
        dp_qin = 4'b1011;
        start  = 1'b1;
        step();
        start  = 1'b0;
        step();
        step();
        chk("rst_in_add", strobes(), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_async_outputs", {27'd0, load, add, shift, busy, done}, 32'd0);
        chk("rst_async_iter", 32'(iter), 32'd0);
        #3;
        reset = 1'b0;
        step();
        chk("rst_release_idle", {27'd0, load, add, shift, busy, done}, 32'd0);
        chk("rst_release_iter", 32'(iter), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
